// File: rtl/mc_pkg.sv
// mc_pkg: shared FSM state, reject-reason and finish-status encodings
// for the Missionaries-and-Cannibals game engine.
package mc_pkg;
  typedef enum logic [1:0] {PLAY, CHECK, WIN, LOSE} state_t;
  localparam logic [1:0] REJ_NONE  = 2'b00;
  localparam logic [1:0] REJ_CAP   = 2'b01;
  localparam logic [1:0] REJ_AVAIL = 2'b10;
  localparam logic [2:0] FIN_PLAY  = 3'b000;
  localparam logic [2:0] FIN_WIN   = 3'b001;
  localparam logic [2:0] FIN_LOSE  = 3'b010;
endpackage

// File: rtl/mc_move_checker.sv
// mc_move_checker: validates one crossing against the current position and
// derives the resulting position plus win/lose status of that position.
module mc_move_checker
  import mc_pkg::*;
#(
  parameter int NUM_PEOPLE = 3,
  parameter int BOAT_CAP   = 2,
  localparam int CNT_W     = $clog2(NUM_PEOPLE + 1)
) (
  input  logic [CNT_W-1:0] missionary_left,
  input  logic [CNT_W-1:0] cannibal_left,
  input  logic             boat_side,
  input  logic [CNT_W-1:0] move_m,
  input  logic [CNT_W-1:0] move_c,
  output logic             legal,
  output logic [1:0]       reject_code,
  output logic [CNT_W-1:0] next_missionary_left,
  output logic [CNT_W-1:0] next_cannibal_left,
  output logic             win,
  output logic             lose
);
  localparam logic [CNT_W-1:0] NP = CNT_W'(NUM_PEOPLE);
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] avail_m, avail_c, right_m, right_c;
  logic             cap_bad, avail_bad;
  // passengers come from whichever bank the boat is currently on
  assign sum       = {1'b0, move_m} + {1'b0, move_c};
  assign cap_bad   = sum == '0 || 32'(sum) > BOAT_CAP;
  assign avail_m   = boat_side ? NP - missionary_left : missionary_left;
  assign avail_c   = boat_side ? NP - cannibal_left : cannibal_left;
  assign avail_bad = move_m > avail_m || move_c > avail_c;
  assign legal       = !cap_bad && !avail_bad;
  assign reject_code = cap_bad ? REJ_CAP : avail_bad ? REJ_AVAIL : REJ_NONE;
  assign next_missionary_left = boat_side ? missionary_left + move_m : missionary_left - move_m;
  assign next_cannibal_left   = boat_side ? cannibal_left + move_c : cannibal_left - move_c;
  assign right_m = NP - next_missionary_left;
  assign right_c = NP - next_cannibal_left;
  assign win  = next_missionary_left == '0 && next_cannibal_left == '0;
  assign lose = (next_missionary_left != '0 && next_cannibal_left > next_missionary_left) ||
                (right_m != '0 && right_c > right_m);
endmodule

// File: rtl/mc_game_engine.sv
// mc_game_engine: interactive Missionaries-and-Cannibals engine; accepts moves
// over valid/ready, checks them one cycle later and tracks position and status.
module mc_game_engine
  import mc_pkg::*;
#(
  parameter int NUM_PEOPLE = 3,
  parameter int BOAT_CAP   = 2,
  parameter int MOVE_W     = 8,
  localparam int CNT_W     = $clog2(NUM_PEOPLE + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              restart,
  input  logic              move_valid,
  output logic              move_ready,
  input  logic [CNT_W-1:0]  move_m,
  input  logic [CNT_W-1:0]  move_c,
  output logic [CNT_W-1:0]  missionary_left,
  output logic [CNT_W-1:0]  cannibal_left,
  output logic              boat_side,
  output logic [MOVE_W-1:0] move_count,
  output logic              reject,
  output logic [1:0]        reject_code,
  output logic [2:0]        finish
);
  localparam logic [CNT_W-1:0] NP = CNT_W'(NUM_PEOPLE);
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  mm_q, mm_d, mc_q, mc_d, ml_q, ml_d, cl_q, cl_d, nml, ncl;
  logic              side_q, side_d, rej_q, rej_d, legal, win, lose;
  logic [MOVE_W-1:0] cnt_q, cnt_d;
  logic [1:0]        code_q, code_d, chk_code;
  logic [2:0]        fin_q, fin_d;
  mc_move_checker #(.NUM_PEOPLE(NUM_PEOPLE), .BOAT_CAP(BOAT_CAP)) u_chk (
    .missionary_left(ml_q), .cannibal_left(cl_q), .boat_side(side_q),
    .move_m(mm_q), .move_c(mc_q), .legal(legal), .reject_code(chk_code),
    .next_missionary_left(nml), .next_cannibal_left(ncl), .win(win), .lose(lose)
  );
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PLAY;
      mm_q    <= '0;
      mc_q    <= '0;
      ml_q    <= NP;
      cl_q    <= NP;
      side_q  <= 1'b0;
      cnt_q   <= '0;
      rej_q   <= 1'b0;
      code_q  <= REJ_NONE;
      fin_q   <= FIN_PLAY;
    end else begin
      state_q <= state_d;
      mm_q    <= mm_d;
      mc_q    <= mc_d;
      ml_q    <= ml_d;
      cl_q    <= cl_d;
      side_q  <= side_d;
      cnt_q   <= cnt_d;
      rej_q   <= rej_d;
      code_q  <= code_d;
      fin_q   <= fin_d;
    end
  end
  always_comb begin
    state_d = state_q;
    mm_d    = mm_q;
    mc_d    = mc_q;
    ml_d    = ml_q;
    cl_d    = cl_q;
    side_d  = side_q;
    cnt_d   = cnt_q;
    fin_d   = fin_q;
    rej_d   = 1'b0;
    code_d  = REJ_NONE;
    case (state_q)
      PLAY: if (move_valid) begin
        state_d = CHECK;
        mm_d    = move_m;
        mc_d    = move_c;
      end
      CHECK: if (legal) begin
        ml_d    = nml;
        cl_d    = ncl;
        side_d  = !side_q;
        cnt_d   = &cnt_q ? cnt_q : cnt_q + 1'b1;
        state_d = win ? WIN : lose ? LOSE : PLAY;
        fin_d   = win ? FIN_WIN : lose ? FIN_LOSE : FIN_PLAY;
      end else begin
        state_d = PLAY;
        rej_d   = 1'b1;
        code_d  = chk_code;
      end
      default: ;
    endcase
    // restart overrides any pending handshake or check result
    if (restart) begin
      state_d = PLAY;
      ml_d    = NP;
      cl_d    = NP;
      side_d  = 1'b0;
      cnt_d   = '0;
      fin_d   = FIN_PLAY;
      rej_d   = 1'b0;
      code_d  = REJ_NONE;
    end
  end
  assign move_ready      = state_q == PLAY;
  assign missionary_left = ml_q;
  assign cannibal_left   = cl_q;
  assign boat_side       = side_q;
  assign move_count      = cnt_q;
  assign reject          = rej_q;
  assign reject_code     = code_q;
  assign finish          = fin_q;
endmodule

// File: tb/tb_mc_game_engine.sv
// tb_mc_game_engine: table-driven and randomized checks of mc_game_engine
// against a rule-level game model (N=3/K=2, N=5/K=3, and a 2-bit counter copy).
module tb_mc_game_engine;
  typedef struct {int ml, cl, side, cnt, fin, rej, code;} mstate_t;
  typedef struct {int m, c, ml, cl, side, cnt, fin;} vec_t;

  logic clock = 1'b0, reset_n = 1'b0, restart = 1'b0, mv = 1'b0;
  logic [1:0] mm = '0, mc = '0;
  logic ready3, side3, rej3, readyS, sideS, rejS;
  logic [1:0] ml3, cl3, code3, mlS, clS, cntS, codeS;
  logic [7:0] cnt3;
  logic [2:0] fin3, finS;
  logic restart5 = 1'b0, mv5 = 1'b0, ready5, side5, rej5;
  logic [2:0] mm5 = '0, mc5 = '0, ml5, cl5, fin5;
  logic [7:0] cnt5;
  logic [1:0] code5;
  int n_chk = 0, n_fail = 0;
  mstate_t m3, mS, m5;
  vec_t sol3[11], sol5[11];

  always #5 clock = ~clock;

  mc_game_engine #(.NUM_PEOPLE(3), .BOAT_CAP(2), .MOVE_W(8)) u3 (
    .clock(clock), .reset_n(reset_n), .restart(restart), .move_valid(mv), .move_ready(ready3),
    .move_m(mm), .move_c(mc), .missionary_left(ml3), .cannibal_left(cl3), .boat_side(side3),
    .move_count(cnt3), .reject(rej3), .reject_code(code3), .finish(fin3));
  mc_game_engine #(.NUM_PEOPLE(3), .BOAT_CAP(2), .MOVE_W(2)) us (
    .clock(clock), .reset_n(reset_n), .restart(restart), .move_valid(mv), .move_ready(readyS),
    .move_m(mm), .move_c(mc), .missionary_left(mlS), .cannibal_left(clS), .boat_side(sideS),
    .move_count(cntS), .reject(rejS), .reject_code(codeS), .finish(finS));
  mc_game_engine #(.NUM_PEOPLE(5), .BOAT_CAP(3), .MOVE_W(8)) u5 (
    .clock(clock), .reset_n(reset_n), .restart(restart5), .move_valid(mv5), .move_ready(ready5),
    .move_m(mm5), .move_c(mc5), .missionary_left(ml5), .cannibal_left(cl5), .boat_side(side5),
    .move_count(cnt5), .reject(rej5), .reject_code(code5), .finish(fin5));

  function automatic mstate_t mreset(int n);
    return '{ml: n, cl: n, side: 0, cnt: 0, fin: 0, rej: 0, code: 0};
  endfunction

  // one attempted crossing under the game rules; terminal games ignore moves
  function automatic mstate_t mstep(mstate_t s, int n, int k, int wmax, int m, int c);
    mstate_t r = s;
    int am, ac;
    r.rej = 0;
    r.code = 0;
    if (s.fin != 0) return r;
    am = s.side ? n - s.ml : s.ml;
    ac = s.side ? n - s.cl : s.cl;
    if (m + c == 0 || m + c > k) begin
      r.rej = 1; r.code = 1;
    end else if (m > am || c > ac) begin
      r.rej = 1; r.code = 2;
    end else begin
      r.ml = s.side ? s.ml + m : s.ml - m;
      r.cl = s.side ? s.cl + c : s.cl - c;
      r.side = 1 - s.side;
      r.cnt = s.cnt < wmax ? s.cnt + 1 : wmax;
      if (r.ml == 0 && r.cl == 0) r.fin = 1;
      else if ((r.ml > 0 && r.cl > r.ml) || (n - r.ml > 0 && n - r.cl > n - r.ml)) r.fin = 2;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input mstate_t s, input int ml, input int cl, input int side,
                     input int cnt, input int fin, input int rej, input int code, input int rdy);
    chk({tag, " missionary_left"}, ml, s.ml);
    chk({tag, " cannibal_left"}, cl, s.cl);
    chk({tag, " boat_side"}, side, s.side);
    chk({tag, " move_count"}, cnt, s.cnt);
    chk({tag, " finish"}, fin, s.fin);
    chk({tag, " reject"}, rej, s.rej);
    chk({tag, " move_ready"}, rdy, s.fin == 0 ? 1 : 0);
    if (s.rej != 0) chk({tag, " reject_code"}, code, s.code);
  endtask

  task automatic cmp3(input string tag);
    cmp(tag, m3, ml3, cl3, side3, cnt3, fin3, rej3, code3, ready3);
    cmp({tag, " sat"}, mS, mlS, clS, sideS, cntS, finS, rejS, codeS, readyS);
  endtask

  task automatic cmp5(input string tag);
    cmp(tag, m5, ml5, cl5, side5, cnt5, fin5, rej5, code5, ready5);
  endtask

  task automatic move3(input int m, input int c);
    @(negedge clock);
    mv = 1'b1; mm = 2'(m); mc = 2'(c);
    @(posedge clock); #1 mv = 1'b0;
    @(posedge clock); #1;
    m3 = mstep(m3, 3, 2, 255, m, c);
    mS = mstep(mS, 3, 2, 3, m, c);
  endtask

  task automatic move5(input int m, input int c);
    @(negedge clock);
    mv5 = 1'b1; mm5 = 3'(m); mc5 = 3'(c);
    @(posedge clock); #1 mv5 = 1'b0;
    @(posedge clock); #1;
    m5 = mstep(m5, 5, 3, 255, m, c);
  endtask

  task automatic restart3();
    @(negedge clock) restart = 1'b1;
    @(posedge clock); #1 restart = 1'b0;
    m3 = mreset(3);
    mS = mreset(3);
  endtask

  initial begin
    sol3 = '{'{0,2,3,1,1,1,0}, '{0,1,3,2,0,2,0}, '{0,2,3,0,1,3,0}, '{0,1,3,1,0,4,0},
             '{2,0,1,1,1,5,0}, '{1,1,2,2,0,6,0}, '{2,0,0,2,1,7,0}, '{0,1,0,3,0,8,0},
             '{0,2,0,1,1,9,0}, '{0,1,0,2,0,10,0}, '{0,2,0,0,1,11,1}};
    sol5 = '{'{0,3,5,2,1,1,0}, '{0,1,5,3,0,2,0}, '{0,3,5,0,1,3,0}, '{0,2,5,2,0,4,0},
             '{3,0,2,2,1,5,0}, '{1,1,3,3,0,6,0}, '{3,0,0,3,1,7,0}, '{0,1,0,4,0,8,0},
             '{0,3,0,1,1,9,0}, '{0,1,0,2,0,10,0}, '{0,2,0,0,1,11,1}};
    m3 = mreset(3); mS = mreset(3); m5 = mreset(5);
    #23 cmp3("in reset");
    cmp5("in reset n5");
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1 cmp3("after reset");
    chk("reset code", code3, 0);

    for (int i = 0; i < 11; i++) begin
      move3(sol3[i].m, sol3[i].c);
      chk($sformatf("classic%0d ml", i), ml3, sol3[i].ml);
      chk($sformatf("classic%0d cl", i), cl3, sol3[i].cl);
      chk($sformatf("classic%0d side", i), side3, sol3[i].side);
      chk($sformatf("classic%0d cnt", i), cnt3, sol3[i].cnt);
      chk($sformatf("classic%0d fin", i), fin3, sol3[i].fin);
      cmp3($sformatf("classic%0d", i));
    end
    move3(0, 1);
    cmp3("after win");

    restart3();
    cmp3("restart after win");
    move3(1, 0);
    chk("loss fin", fin3, 2);
    cmp3("loss");
    move3(0, 1);
    cmp3("loss ignore");

    restart3();
    move3(0, 0);
    chk("rej00 code", code3, 1);
    cmp3("rej00");
    @(posedge clock); #1 chk("reject pulse width", rej3, 0);
    move3(2, 1);
    chk("rej21 code", code3, 1);
    cmp3("rej21");
    move3(0, 2);
    cmp3("legal02");
    move3(1, 0);
    chk("avail code", code3, 2);
    cmp3("avail");

    @(negedge clock);
    mv = 1'b1; mm = 2'd0; mc = 2'd1;
    @(posedge clock); #1 mv = 1'b0; restart = 1'b1;
    @(posedge clock); #1 restart = 1'b0;
    m3 = mreset(3); mS = mreset(3);
    chk("restart in check cnt", cnt3, 0);
    cmp3("restart in check");

    move3(0, 2);
    @(negedge clock);
    mv = 1'b1; mm = 2'd0; mc = 2'd1;
    @(posedge clock); #1 mv = 1'b0;
    #2 reset_n = 1'b0;
    #1 m3 = mreset(3); mS = mreset(3); m5 = mreset(5);
    cmp3("async reset");
    @(negedge clock) reset_n = 1'b1;

    restart3();
    for (int i = 1; i <= 6; i++) begin
      move3(0, 1);
      chk($sformatf("sat cnt%0d", i), cntS, i < 3 ? i : 3);
      chk($sformatf("sat fin%0d", i), finS, 0);
      cmp3($sformatf("sat%0d", i));
    end

    move5(2, 2);
    chk("n5 cap code", code5, 1);
    cmp5("n5 cap");
    for (int i = 0; i < 11; i++) begin
      move5(sol5[i].m, sol5[i].c);
      chk($sformatf("n5 sol%0d ml", i), ml5, sol5[i].ml);
      chk($sformatf("n5 sol%0d cl", i), cl5, sol5[i].cl);
      chk($sformatf("n5 sol%0d cnt", i), cnt5, sol5[i].cnt);
      chk($sformatf("n5 sol%0d fin", i), fin5, sol5[i].fin);
      cmp5($sformatf("n5 sol%0d", i));
    end

    restart3();
    for (int i = 0; i < 300; i++) begin
      if (m3.fin != 0 || $urandom_range(0, 15) == 0) restart3();
      else move3(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      cmp3($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mc_game_engine.md
# mc_game_engine

Parametrised, interactive Missionaries-and-Cannibals game engine for N missionaries, N cannibals and a boat of capacity K. It replaces the fixed 12-state auto-sequencer. It accepts player move requests over a valid/ready handshake, validates each move and updates the bank occupancy. It detects win and loss conditions and counts accepted moves. It sits between the board switch/button front end and the 7-segment/LED display logic.

## Interface
Parameters:
- `NUM_PEOPLE`, default 3: missionaries per side (and cannibals per side); must be ≥1.
- `BOAT_CAP`, default 2: maximum passengers per crossing; must be ≥1.
- `MOVE_W`, default 8: width of the move counter.
- `CNT_W` (localparam): `$clog2(NUM_PEOPLE+1)`, width of every person count.

Ports:
- `clock`, in, 1: system clock, rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `restart`, in, 1: synchronous game restart, active high.
- `move_valid`, in, 1: a move request is present.
- `move_ready`, out, 1: the engine can accept a move.
- `move_m`, in, CNT_W: missionaries in the boat.
- `move_c`, in, CNT_W: cannibals in the boat.
- `missionary_left`, out, CNT_W: missionaries on the original (left) bank.
- `cannibal_left`, out, CNT_W: cannibals on the original (left) bank.
- `boat_side`, out, 1: boat position; 0 = left, 1 = right.
- `move_count`, out, MOVE_W: number of accepted legal moves; saturates at all-ones.
- `reject`, out, 1: one-cycle pulse when a move is refused.
- `reject_code`, out, 2: reason for the refusal; valid while `reject`=1.
- `finish`, out, 3: game status. 000 = playing, 001 = won, 010 = lost.

## Operation
States: PLAY, CHECK, WIN, LOSE.

- **PLAY**
  - `move_ready`=1.
  - A handshake (`move_valid` & `move_ready`) registers `move_m`/`move_c` and moves the FSM to CHECK.
- **CHECK**
  - `move_ready`=0. Legality is evaluated against the registered move, with sum computed at CNT_W+1 bits.
  - Capacity check: if `m+c`==0 or `m+c`>BOAT_CAP, the move is rejected with code 01.
  - Availability check, applied only if the capacity check passes:
    - boat left: `m`≤`missionary_left` and `c`≤`cannibal_left`.
    - boat right: `m`≤NUM_PEOPLE−`missionary_left` and `c`≤NUM_PEOPLE−`cannibal_left`.
    - On failure the move is rejected with code 10.
  - On reject: `reject` pulses, position and counter are unchanged, and the FSM returns to PLAY.
  - On a legal move:
    - Subtract `m`/`c` from the left bank (boat left) or add them (boat right).
    - Toggle `boat_side` and increment `move_count` (saturating).
    - Next state is evaluated on the *new* position:
      - WIN if left is (0,0).
      - Otherwise LOSE if either bank has missionaries>0 and cannibals>missionaries.
      - Otherwise PLAY.
- **WIN** and **LOSE**
  - Terminal states. `move_ready`=0 and `finish` is held at 001 or 010 respectively.
  - Only `restart` or `reset_n` exits these states.
- **restart**
  - Accepted from any state.
  - At the next edge: FSM goes to PLAY, position returns to (N,N,left), `move_count`=0, `reject`=0.
  - Wins over a simultaneous handshake or CHECK result; the pending move is discarded.

## Timing
- Reset values: FSM in PLAY, `missionary_left`=`cannibal_left`=NUM_PEOPLE, `boat_side`=0, `move_count`=0, `finish`=000, `reject`=0, `reject_code`=00, `move_ready`=1.
- `reset_n` low at any time, including during CHECK, forces the reset values immediately, without waiting for a clock edge.
- Handshake at edge t: CHECK occupies cycle t..t+1. Position, count, `finish` and `reject` update at edge t+1 (latency 1 cycle after acceptance).
- After a legal move, the earliest next handshake is edge t+2. `move_ready` is low for exactly one cycle per move.
- `move_m`/`move_c` only need to be stable at the handshake edge.
- All outputs are registered except `move_ready`, which is decoded from the state (Moore).

## Structure
- Package `mc_pkg` holds:
  - the state enum (PLAY, CHECK, WIN, LOSE);
  - reject codes: REJ_NONE=00, REJ_CAP=01, REJ_AVAIL=10;
  - finish codes: FIN_PLAY=000, FIN_WIN=001, FIN_LOSE=010.
- Sub-module `mc_move_checker` is purely combinational and parametrised by NUM_PEOPLE and BOAT_CAP.
  - Inputs: current position and move.
  - Outputs: `legal`, `reject_code`, next position, `win`, `lose`.
  - The top level holds the FSM, registers and counter.

## Test plan
- Classic solution, N=3, K=2. Moves (0,2),(0,1),(0,2),(0,1),(2,0),(1,1),(2,0),(0,1),(0,2),(0,1),(0,2) → `finish`=001, `move_count`=11, position (0,0,1), `move_ready`=0 thereafter.
- Loss, N=3, K=2. From reset, move (1,0) → left bank (2,3) → `finish`=010 one cycle after acceptance; further `move_valid` is ignored.
- Illegal moves, each with position and count unchanged:
  - (0,0) → `reject`=1, code 01.
  - (2,1) → `reject`=1, code 01.
  - Move (0,2), then (1,0) with the boat right → code 10.
- Restart and reset interaction:
  - `restart` asserted in the same cycle as CHECK of a legal move → next cycle position (3,3,0), `move_count`=0, `finish`=000.
  - `reset_n` pulsed low mid-cycle → outputs at reset values before the next clock edge.
- Parameter sweep at N=5, K=3 with a known 11-move solution → `finish`=001. A 4-passenger move is rejected with code 01.
- Counter saturation with MOVE_W=2, alternating legal moves (0,1) and (0,1): `move_count` sticks at 3 and `finish` stays 000.
